// File: rtl/count_seq_checker.sv
// count_seq_checker: on-chip sequence monitor for an 8-bit loadable up-counter.
// It predicts each next counter value from the previous cycle's value and controls.
// It then compares the prediction with the observed bus and reports lock,
// error strobe, saturating error count and the first mismatch seen.
// Optional feature: define COUNT_SEQ_CHECKER_WRAP_EN to count observed
// all-ones->0 wraps while tracking. When it is undefined, wrap_count is tied to 0.
module count_seq_checker #(
  parameter int WIDTH    = 8,
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_en,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_stats,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             first_vld,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got,
  output logic [ERR_W-1:0] wrap_count
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);

  localparam logic [1:0] ST_UNSYNC  = 2'd0;
  localparam logic [1:0] ST_SYNCING = 2'd1;
  localparam logic [1:0] ST_TRACK   = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [RUN_W-1:0] run_reg, run_next, run_inc;
  logic             locked_reg, locked_next;

  logic [WIDTH-1:0] h_cnt_reg, h_val_reg;
  logic             h_en_reg, h_load_reg;

  logic [WIDTH-1:0] exp_val;
  logic             match;
  logic             mismatch_track;

  logic             err_pulse_reg;
  logic [ERR_W-1:0] err_count_reg;
  logic             first_vld_reg;
  logic [WIDTH-1:0] first_exp_reg, first_got_reg;

  // Predict this cycle's counter value from last cycle's view (load beats enable).
  always_comb begin
    exp_val = h_cnt_reg;
    if (h_load_reg) begin
      exp_val = h_val_reg;
    end else if (h_en_reg) begin
      exp_val = h_cnt_reg + 1'b1;
    end
    match = (exp_val == cnt_in);
  end

  // Lock FSM: build history, count a run of matches, then track until a mismatch.
  always_comb begin
    state_next     = state_reg;
    run_next       = run_reg;
    locked_next    = locked_reg;
    mismatch_track = 1'b0;
    run_inc        = run_reg + 1'b1;
    case (state_reg)
      ST_UNSYNC: begin
        state_next = ST_SYNCING;
      end
      ST_SYNCING: begin
        if (match) begin
          if (run_inc == LOCK_RUN) begin
            state_next  = ST_TRACK;
            locked_next = 1'b1;
            run_next    = '0;
          end else begin
            run_next = run_inc;
          end
        end else begin
          run_next = '0;
        end
      end
      ST_TRACK: begin
        if (!match) begin
          mismatch_track = 1'b1;
          locked_next    = 1'b0;
          run_next       = '0;
          state_next     = ST_SYNCING;
        end
      end
      default: begin
        state_next  = ST_UNSYNC;
        run_next    = '0;
        locked_next = 1'b0;
      end
    endcase
  end

  // State, run count, lock flag and one-cycle history of the monitored bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_UNSYNC;
      run_reg    <= '0;
      locked_reg <= 1'b0;
      h_cnt_reg  <= '0;
      h_en_reg   <= 1'b0;
      h_load_reg <= 1'b0;
      h_val_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      run_reg    <= run_next;
      locked_reg <= locked_next;
      h_cnt_reg  <= cnt_in;
      h_en_reg   <= cnt_en;
      h_load_reg <= load_in;
      h_val_reg  <= load_val;
    end
  end

  // Error statistics; clr_stats wins over a simultaneous mismatch, but the strobe still fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse_reg <= 1'b0;
      err_count_reg <= '0;
      first_vld_reg <= 1'b0;
      first_exp_reg <= '0;
      first_got_reg <= '0;
    end else begin
      err_pulse_reg <= mismatch_track;
      if (clr_stats) begin
        err_count_reg <= '0;
        first_vld_reg <= 1'b0;
        first_exp_reg <= '0;
        first_got_reg <= '0;
      end else if (mismatch_track) begin
        if (err_count_reg != {ERR_W{1'b1}}) begin
          err_count_reg <= err_count_reg + 1'b1;
        end
        if (!first_vld_reg) begin
          first_vld_reg <= 1'b1;
          first_exp_reg <= exp_val;
          first_got_reg <= cnt_in;
        end
      end
    end
  end

`ifdef COUNT_SEQ_CHECKER_WRAP_EN
  logic [ERR_W-1:0] wrap_count_reg;

  // Count correctly predicted natural wraps (all-ones counting up to zero) while tracking.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      wrap_count_reg <= '0;
    end else if ((state_reg == ST_TRACK) && match && h_en_reg && !h_load_reg &&
                 (h_cnt_reg == {WIDTH{1'b1}}) && (wrap_count_reg != {ERR_W{1'b1}})) begin
      wrap_count_reg <= wrap_count_reg + 1'b1;
    end
  end

  assign wrap_count = wrap_count_reg;
`else
  assign wrap_count = '0;
`endif

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;
  assign first_vld = first_vld_reg;
  assign first_exp = first_exp_reg;
  assign first_got = first_got_reg;

endmodule
